boreal_csp_cfg_ctrl: RTL and testbench

BOREAL_CSP_CFG_CTRL -- requirements
Module: boreal_csp_cfg_ctrl

---
 rtl/boreal_csp_pkg.sv | 24 ++
 rtl/boreal_csp_cfg_ctrl.sv | 161 ++++++++++++++++
 tb/tb_boreal_csp_cfg_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boreal_csp_pkg.sv
// Shared definitions for the CSP filter configuration controller: FSM encoding,
// MMIO address map, filter power-up weights and watchdog default.
package boreal_csp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } csp_state_e;

    localparam logic [4:0]  ADDR_COMMIT      = 5'd16;
    localparam logic [4:0]  ADDR_CLR         = 5'd17;
    localparam int          N_WEIGHTS        = 16;
    localparam int          WD_LIMIT_DEFAULT = 15;
    localparam logic [15:0] W_UNITY          = 16'h1000;
    localparam logic [15:0] DROP_MAX         = 16'hFFFF;

    // Filter wakes up with unity gain on taps 1 and 10; the shadow must match.
    function automatic logic [15:0] default_weight(input logic [3:0] idx);
        return (idx == 4'd1 || idx == 4'd10) ? W_UNITY : 16'h0000;
    endfunction

endpackage

// File: rtl/boreal_csp_cfg_ctrl.sv
// Frame gatekeeper and weight loader for the CSP filter: forwards one frame at a
// time, and on commit drains the filter then streams the 16 shadow weights into it.
module boreal_csp_cfg_ctrl
    import boreal_csp_pkg::*;
#(
    parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mmio_we,
    input  logic [4:0]   mmio_addr,
    input  logic [15:0]  mmio_wdata,
    input  logic         frame_in_valid,
    input  logic [127:0] frame_in,
    output logic         csp_valid,
    output logic [127:0] csp_frame,
    input  logic         csp_out_valid,
    output logic         csp_we,
    output logic [3:0]   csp_addr,
    output logic [15:0]  csp_weight,
    output logic         busy,
    output logic         load_done,
    output logic [15:0]  drop_cnt,
    output logic         wr_err,
    output logic         wd_err
);

    // state | meaning
    // IDLE  | frames forwarded, shadow writable
    // DRAIN | waiting for the in-flight frame to return
    // LOAD  | streaming shadow[0..15] to the filter, one per cycle
    // DONE  | load_done pulse, then IDLE or another DRAIN on recommit

    csp_state_e  state;
    logic        inflight;
    logic        recommit;
    logic [15:0] wd_cnt;
    logic [15:0] shadow [N_WEIGHTS];

    logic in_idle;
    logic shadow_wr;
    logic commit_wr;
    logic clr_wr;
    logic fwd;
    logic wd_fire;

    assign in_idle   = (state == ST_IDLE);
    assign shadow_wr = mmio_we && !mmio_addr[4];
    assign commit_wr = mmio_we && (mmio_addr == ADDR_COMMIT);
    assign clr_wr    = mmio_we && (mmio_addr == ADDR_CLR);
    assign fwd       = frame_in_valid && in_idle && !inflight;
    assign wd_fire   = inflight && !csp_out_valid && (wd_cnt <= 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            inflight   <= 1'b0;
            recommit   <= 1'b0;
            wd_cnt     <= 16'd0;
            csp_valid  <= 1'b0;
            csp_frame  <= '0;
            csp_we     <= 1'b0;
            csp_addr   <= 4'd0;
            csp_weight <= 16'd0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            drop_cnt   <= 16'd0;
            wr_err     <= 1'b0;
            wd_err     <= 1'b0;
            for (int i = 0; i < N_WEIGHTS; i++) begin
                shadow[i] <= default_weight(4'(i));
            end
        end else begin
            csp_valid <= fwd;
            load_done <= 1'b0;

            if (fwd) begin
                csp_frame <= frame_in;
            end

            if (frame_in_valid && !fwd && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            // Watchdog is a down-counter armed on issue; terminal count drops the frame.
            if (fwd) begin
                inflight <= 1'b1;
                wd_cnt   <= 16'(WD_LIMIT);
            end else if (inflight) begin
                if (csp_out_valid || wd_fire) begin
                    inflight <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt - 16'd1;
                end
            end

            if (shadow_wr && in_idle) begin
                shadow[mmio_addr[3:0]] <= mmio_wdata;
            end

            // Clear first so a coincident error event still lands.
            if (clr_wr) begin
                wr_err <= 1'b0;
                wd_err <= 1'b0;
            end
            if (shadow_wr && !in_idle) begin
                wr_err <= 1'b1;
            end
            if (wd_fire) begin
                wd_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    csp_we <= 1'b0;
                    if (commit_wr) begin
                        state <= ST_DRAIN;
                        busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight) begin
                        state      <= ST_LOAD;
                        csp_we     <= 1'b1;
                        csp_addr   <= 4'd0;
                        csp_weight <= shadow[0];
                    end
                end
                ST_LOAD: begin
                    if (csp_addr == 4'd15) begin
                        state     <= ST_DONE;
                        csp_we    <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        csp_addr   <= csp_addr + 4'd1;
                        csp_weight <= shadow[csp_addr + 4'd1];
                    end
                end
                ST_DONE: begin
                    if (recommit) begin
                        state    <= ST_DRAIN;
                        recommit <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A commit arriving in DONE must survive DONE's own clear.
            if (commit_wr && !in_idle) begin
                recommit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boreal_csp_cfg_ctrl.sv
// Directed bench for boreal_csp_cfg_ctrl: forwarding, drops, weight loads,
// error flags, watchdog, recommit and reset mid-load.
module tb_boreal_csp_cfg_ctrl;

    logic         clk;
    logic         rst;
    logic         mmio_we;
    logic [4:0]   mmio_addr;
    logic [15:0]  mmio_wdata;
    logic         frame_in_valid;
    logic [127:0] frame_in;
    logic         csp_valid;
    logic [127:0] csp_frame;
    logic         csp_out_valid;
    logic         csp_we;
    logic [3:0]   csp_addr;
    logic [15:0]  csp_weight;
    logic         busy;
    logic         load_done;
    logic [15:0]  drop_cnt;
    logic         wr_err;
    logic         wd_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_sh [16];

    localparam logic [127:0] F1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [127:0] F2 = 128'hA5A5_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] F3 = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] F4 = 128'h0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0;
    localparam logic [127:0] F5 = 128'h7FFF_8000_7FFF_8000_7FFF_8000_7FFF_8000;
    localparam logic [127:0] F6 = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
    localparam logic [127:0] F7 = 128'hC0DE_CAFE_F00D_BABE_0BAD_FACE_1DEA_5EED;

    boreal_csp_cfg_ctrl #(.WD_LIMIT(15)) dut (
        .clk(clk), .rst(rst),
        .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .frame_in_valid(frame_in_valid), .frame_in(frame_in),
        .csp_valid(csp_valid), .csp_frame(csp_frame), .csp_out_valid(csp_out_valid),
        .csp_we(csp_we), .csp_addr(csp_addr), .csp_weight(csp_weight),
        .busy(busy), .load_done(load_done), .drop_cnt(drop_cnt),
        .wr_err(wr_err), .wd_err(wd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_sh[i] = 16'h0000;
        model_sh[1]  = 16'h1000;
        model_sh[10] = 16'h1000;
    endtask

    task automatic wait_load_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (load_done === 1'b1) seen = 1'b1;
        end
    endtask

    // Called right after the edge that enters LOAD; returns after the edge into DONE.
    task automatic check_load_seq(input string tag);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({csp_we, csp_addr, csp_weight} !== {1'b1, 4'(i), model_sh[i]}) begin
                n_fail++;
                $display("FAIL %s write %0d: got we=%b addr=%0d w=%h, want we=1 addr=%0d w=%h",
                         tag, i, csp_we, csp_addr, csp_weight, i, model_sh[i]);
            end
            tick();
        end
        n_checks++;
        if ({csp_we, load_done, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL %s done: got we=%b load_done=%b busy=%b, want 0 1 1",
                     tag, csp_we, load_done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({busy, csp_valid, csp_we, csp_addr, csp_weight, load_done, drop_cnt, wr_err, wd_err} !== '0
            || csp_frame !== '0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b vld=%b we=%b addr=%0d w=%h ld=%b drop=%0d wr=%b wd=%b frame=%h, want all 0",
                     busy, csp_valid, csp_we, csp_addr, csp_weight, load_done, drop_cnt, wr_err, wd_err, csp_frame);
        end
    endtask

    task automatic test_forward();
        frame_in_valid = 1'b1; frame_in = F1;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F1) begin
            n_fail++;
            $display("FAIL forward_latency: got vld=%b frame=%h, want 1 %h", csp_valid, csp_frame, F1);
        end
        tick();
        n_checks++;
        if (csp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL forward_pulse: got vld=%b, want 0", csp_valid);
        end
        repeat (4) tick();
        csp_out_valid = 1'b1;
        tick();
        csp_out_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL forward_drop_cnt: got %0d, want 0", drop_cnt);
        end
        frame_in_valid = 1'b1; frame_in = F2;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F2) begin
            n_fail++;
            $display("FAIL forward_after_return: got vld=%b frame=%h, want 1 %h", csp_valid, csp_frame, F2);
        end
    endtask

    task automatic test_drop_inflight();
        tick();
        frame_in_valid = 1'b1; frame_in = F3;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b0 || csp_frame !== F2 || drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_inflight: got vld=%b frame=%h drop=%0d, want 0 %h 1", csp_valid, csp_frame, drop_cnt, F2);
        end
    endtask

    task automatic test_commit_drain();
        mmio_we = 1'b1; mmio_addr = 5'd3; mmio_wdata = 16'h0800;
        tick();
        model_sh[3] = 16'h0800;
        mmio_addr = 5'd16;
        tick();
        mmio_we = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || csp_we !== 1'b0 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_enter_drain: got busy=%b we=%b wr_err=%b, want 1 0 0", busy, csp_we, wr_err);
        end
        frame_in_valid = 1'b1; frame_in = F3;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b0 || drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_in_drain: got vld=%b drop=%0d, want 0 2", csp_valid, drop_cnt);
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || csp_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_hold: got busy=%b we=%b, want 1 0", busy, csp_we);
        end
        csp_out_valid = 1'b1;
        tick();
        csp_out_valid = 1'b0;
        n_checks++;
        if (csp_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit_timing: got we=%b, want 0", csp_we);
        end
        tick();
        check_load_seq("load1");
        tick();
        n_checks++;
        if (busy !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load1_idle: got busy=%b load_done=%b, want 0 0", busy, load_done);
        end
    endtask

    task automatic test_watchdog();
        frame_in_valid = 1'b1; frame_in = F4;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F4) begin
            n_fail++;
            $display("FAIL wd_forward: got vld=%b frame=%h, want 1 %h", csp_valid, csp_frame, F4);
        end
        repeat (14) tick();
        n_checks++;
        if (wd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early: got wd_err=%b after 14 cycles, want 0", wd_err);
        end
        tick();
        n_checks++;
        if (wd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_fire: got wd_err=%b after 15 cycles, want 1", wd_err);
        end
        mmio_we = 1'b1; mmio_addr = 5'd17;
        tick();
        mmio_we = 1'b0;
        n_checks++;
        if (wd_err !== 1'b0 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: got wd_err=%b wr_err=%b, want 0 0", wd_err, wr_err);
        end
        frame_in_valid = 1'b1; frame_in = F5;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F5) begin
            n_fail++;
            $display("FAIL wd_next_forward: got vld=%b frame=%h, want 1 %h", csp_valid, csp_frame, F5);
        end
        repeat (14) tick();
        mmio_we = 1'b1; mmio_addr = 5'd17;
        tick();
        mmio_we = 1'b0;
        n_checks++;
        if (wd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_set_beats_clear: got wd_err=%b, want 1", wd_err);
        end
        frame_in_valid = 1'b1; frame_in = F6;
        tick();
        frame_in_valid = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F6 || drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL wd_forward_after_fire: got vld=%b frame=%h drop=%0d, want 1 %h 2", csp_valid, csp_frame, drop_cnt, F6);
        end
        csp_out_valid = 1'b1;
        tick();
        csp_out_valid = 1'b0;
    endtask

    task automatic test_simul_frame_commit();
        bit seen;
        frame_in_valid = 1'b1; frame_in = F7;
        mmio_we = 1'b1; mmio_addr = 5'd16;
        tick();
        frame_in_valid = 1'b0; mmio_we = 1'b0;
        n_checks++;
        if (csp_valid !== 1'b1 || csp_frame !== F7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_frame_commit: got vld=%b frame=%h busy=%b, want 1 %h 1", csp_valid, csp_frame, busy, F7);
        end
        tick();
        tick();
        n_checks++;
        if (csp_we !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drain_wait: got we=%b, want 0", csp_we);
        end
        csp_out_valid = 1'b1;
        tick();
        csp_out_valid = 1'b0;
        wait_load_done(seen);
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_load_done: got seen=%b within 40 cycles, want 1", seen);
        end
        tick();
    endtask

    task automatic test_recommit_wr_err();
        bit seen;
        mmio_we = 1'b1; mmio_addr = 5'd16;
        tick();
        mmio_we = 1'b0;
        tick();
        mmio_we = 1'b1; mmio_addr = 5'd5; mmio_wdata = 16'h1234;
        tick();
        n_checks++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_in_load: got wr_err=%b, want 1", wr_err);
        end
        mmio_addr = 5'd16;
        tick();
        mmio_we = 1'b0;
        wait_load_done(seen);
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL recommit_first_done: got seen=%b, want 1", seen);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || csp_we !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL recommit_redrain: got busy=%b we=%b ld=%b, want 1 0 0", busy, csp_we, load_done);
        end
        tick();
        check_load_seq("load_recommit");
        tick();
        mmio_we = 1'b1; mmio_addr = 5'd17;
        tick();
        mmio_addr = 5'd20;
        tick();
        mmio_we = 1'b0;
        n_checks++;
        if (wr_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_and_ignore: got wr_err=%b busy=%b, want 0 0", wr_err, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int we_seen;
        mmio_we = 1'b1; mmio_addr = 5'd16;
        tick();
        mmio_we = 1'b0;
        tick();
        repeat (7) tick();
        n_checks++;
        if (csp_we !== 1'b1 || csp_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL pre_reset_load: got we=%b addr=%0d, want 1 7", csp_we, csp_addr);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, csp_valid, csp_we, csp_addr, csp_weight, load_done, drop_cnt, wr_err, wd_err} !== '0
            || csp_frame !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_load: busy=%b vld=%b we=%b addr=%0d w=%h ld=%b drop=%0d wr=%b wd=%b, want all 0",
                     busy, csp_valid, csp_we, csp_addr, csp_weight, load_done, drop_cnt, wr_err, wd_err);
        end
        rst = 1'b0;
        model_reset();
        we_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (csp_we !== 1'b0) we_seen++;
        end
        n_checks++;
        if (we_seen != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d csp_we cycles, want 0", we_seen);
        end
        mmio_we = 1'b1; mmio_addr = 5'd16;
        tick();
        mmio_we = 1'b0;
        tick();
        check_load_seq("load_defaults");
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mmio_we = 1'b0; mmio_addr = 5'd0; mmio_wdata = 16'd0;
        frame_in_valid = 1'b0; frame_in = '0; csp_out_valid = 1'b0;
        test_reset();
        test_forward();
        test_drop_inflight();
        test_commit_drain();
        test_watchdog();
        test_simul_frame_commit();
        test_recommit_wr_err();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
